// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - iterative radix-4 Booth unsigned multiplier, one digit per clock.
// Optional macro BOOTH_SEQ_MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.

module booth_pp_lut #(
    parameter int N = 11
) (
    input  logic [N-1:0] a_i,
    input  logic [2:0]   sel_i,
    output logic [N+1:0] pp_o
);
    // Negative digits come out one's-complemented; the caller adds sel[2] as carry-in.
    always_comb begin
        pp_o = '0;
        case (sel_i)
            3'b000:          pp_o = '0;
            3'b001, 3'b010:  pp_o = {2'b00, a_i};
            3'b011:          pp_o = {1'b0, a_i, 1'b0};
            3'b100:          pp_o = ~{1'b0, a_i, 1'b0};
            3'b101, 3'b110:  pp_o = ~{2'b00, a_i};
            default:         pp_o = '1;
        endcase
    end
endmodule

module booth_seq_mult #(
    parameter int N = 11
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product
);
    localparam int D  = N / 2 + 1;
    localparam int AW = 2 * N + 2;
    localparam int BW = 2 * D + 1;
    localparam int CW = $clog2(D + 1);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(D - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [AW-1:0] acc_q, acc_d;

    logic [BW-1:0] b_ext;
    logic [2:0]    sel;
    logic [N+1:0]  pp;
    logic [AW-1:0] pp_ext;
    logic [AW-1:0] term;
    logic          last_digit;
    int            idx;

    // b[-1] = 0 at the bottom, zero padding above the MSB.
    assign b_ext  = {{(BW-N-1){1'b0}}, b_q, 1'b0};
    assign idx    = 2 * int'(cnt_q);
    assign sel    = b_ext[idx +: 3];

    booth_pp_lut #(.N(N)) u_lut (
        .a_i   (a_q),
        .sel_i (sel),
        .pp_o  (pp)
    );

    assign pp_ext = {{(AW-N-2){pp[N+1]}}, pp};
    assign term   = (pp_ext + AW'(sel[2])) << idx;

`ifdef BOOTH_SEQ_MULT_EARLY_EXIT_EN
    logic [N-1:0] rest_bits;
    // Bits from b[2i+1] upward: the pending low bit of the next digit plus everything above.
    assign rest_bits  = b_q >> (idx + 1);
    assign last_digit = (cnt_q == LAST_DIGIT) || (rest_bits == '0);
`else
    assign last_digit = (cnt_q == LAST_DIGIT);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                acc_d = acc_q + term;
                cnt_d = cnt_q + 1'b1;
                if (last_digit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign product   = acc_q[2*N-1:0];
endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 Parameter: N, default 11, operand width in bits (unsigned mantissa incl. hidden bit); legal N >= 3.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand pair a/b presented.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  N  multiplicand, unsigned.
REQ-007 b  input  N  multiplier, unsigned.
REQ-008 out_valid  output  1  product is valid.
REQ-009 out_ready  input  1  consumer accepts product.
REQ-010 product  output  2N  unsigned a*b.

Function
REQ-011 Iterative radix-4 Booth multiplier; one Booth digit retired per clock; digit count D = N/2 + 1 (integer division), D = 6 for N = 11.
REQ-012 Digit i select = {b[2i+1], b[2i], b[2i-1]}; b[-1] = 0; bits above N-1 read as 0.
REQ-013 Select encoding: 000/111 -> 0; 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A.
REQ-014 Partial-product generation uses the existing LUT block (parameter N): LUT output is one's-complement for negative digits; sel[2] is added as carry-in at digit weight 4^i to complete two's complement.
REQ-015 Internal accumulator is signed, 2N+2 bits; product = accumulator[2N-1:0]; result exact for every a, b in [0, 2^N-1].
REQ-016 FSM states: IDLE, BUSY, DONE.
REQ-017 IDLE: in_ready = 1; in_valid = 1 on an edge -> latch a, b, clear accumulator, digit counter = 0, go BUSY.
REQ-018 BUSY: in_ready = 0; each edge adds digit counter's partial product, increments counter; after digit D-1 -> DONE.
REQ-019 Latency: out_valid high D edges after the accepting edge (fixed, macro absent).
REQ-020 DONE: out_valid = 1, product stable; out_ready = 1 on an edge -> IDLE, out_valid deasserts next cycle.
REQ-021 in_valid while BUSY or DONE is ignored; a/b changes after acceptance do not affect the result.
REQ-022 out_ready while IDLE or BUSY has no effect; DONE holds indefinitely under back-pressure.
REQ-023 Throughput: at most one operation per D+2 cycles; no acceptance in the DONE->IDLE edge.

Reset
REQ-024 rst_n low, at any time incl. mid-BUSY: immediately state = IDLE, in_ready = 1, out_valid = 0, product = 0, accumulator/counter/latched operands = 0.
REQ-025 In-flight operation is discarded; no out_valid pulse follows reset release.
REQ-026 First acceptance possible on the first rising edge with rst_n high.

Configuration
REQ-027 Macro BOOTH_SEQ_MULT_EARLY_EXIT_EN.
REQ-028 Defined: BUSY -> DONE as soon as all remaining multiplier bits (incl. pending b[2i-1]) are zero after the current digit; latency = max(1, index of last nonzero digit + 1) edges; result unchanged.
REQ-029 Not defined: fixed latency D per REQ-019; no early-exit logic synthesized.

Verification
REQ-030 a=2047, b=2047, out_ready=1 -> product=4190209, out_valid 6 edges after acceptance (macro absent).
REQ-031 a=0, b=1234 and a=1234, b=0 -> product=0 both; a=1, b=1 -> product=1.
REQ-032 a=5, b=3 with out_ready=0 for 10 cycles after out_valid -> product=15 held stable, in_ready=0, second in_valid ignored until handshake completes.
REQ-033 rst_n pulsed low in 3rd BUSY cycle of a=100, b=200 -> out_valid=0, product=0, in_ready=1 immediately; next op a=7, b=9 -> product=63.
REQ-034 a=100, b=1: macro defined -> out_valid 1 edge after acceptance, product=100; macro absent -> 6 edges, product=100.
REQ-035 10,000 random a, b back-to-back with random out_ready -> every product equals reference a*b, no lost or duplicated results.
